// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit.
// S1 captures operands on input transfer; S2 computes the selected operation,
// registers the result with zero/parity flags, and updates the accumulator.
// Valid/ready handshake on both sides, no skid buffer.
module logic_unit_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int OPCODE_SIZE = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [DATA_WIDTH-1:0]  a_in,
  input  logic [DATA_WIDTH-1:0]  b_in,
  input  logic [OPCODE_SIZE-1:0] opcode_in,
  input  logic                   acc_sel_in,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [DATA_WIDTH-1:0]  y_out,
  output logic                   zero_out,
  output logic                   parity_out
);

  // Opcodes 0-3 match the legacy 8-bit logic unit encodings.
  typedef enum logic [2:0] {
    OP_OR   = 3'd0,
    OP_XOR  = 3'd1,
    OP_AND  = 3'd2,
    OP_NOTA = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NAND = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  // Stage 1 registers
  logic                   s1_valid;
  logic [DATA_WIDTH-1:0]  s1_a;
  logic [DATA_WIDTH-1:0]  s1_b;
  logic [OPCODE_SIZE-1:0] s1_op;
  logic                   s1_acc;

  // Stage 2 registers
  logic                   s2_valid;
  logic [DATA_WIDTH-1:0]  y_reg;
  logic                   zero_reg;
  logic                   parity_reg;
  logic [DATA_WIDTH-1:0]  acc_reg;

  // Handshake and datapath combinational nets
  logic                   s2_adv;
  logic                   in_xfer;
  logic [DATA_WIDTH-1:0]  op_a;
  logic [DATA_WIDTH-1:0]  result;

  // Advance S1 into S2 when S2 is empty or draining this cycle.
  always_comb begin
    s2_adv    = s1_valid & (~s2_valid | ready_in);
    ready_out = ~s1_valid | s2_adv;
    in_xfer   = valid_in & ready_out;
  end

  // Stage 1: capture operands on input transfer, empty when advanced without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_acc   <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_a     <= a_in;
      s1_b     <= b_in;
      s1_op    <= opcode_in;
      s1_acc   <= acc_sel_in;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Operand A selection and bitwise operation for the beat sitting in S1.
  always_comb begin
    op_a   = s1_acc ? acc_reg : s1_a;
    result = '0;
    case (op_e'(s1_op))
      OP_OR:   result = op_a | s1_b;
      OP_XOR:  result = op_a ^ s1_b;
      OP_AND:  result = op_a & s1_b;
      OP_NOTA: result = ~op_a;
      OP_NOR:  result = ~(op_a | s1_b);
      OP_XNOR: result = ~(op_a ^ s1_b);
      OP_NAND: result = ~(op_a & s1_b);
      OP_PASS: result = s1_b;
      default: result = '0;
    endcase
  end

  // Stage 2: register result, flags and accumulator on load; clear valid on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      y_reg      <= '0;
      zero_reg   <= 1'b1;
      parity_reg <= 1'b0;
      acc_reg    <= '0;
    end else if (s2_adv) begin
      s2_valid   <= 1'b1;
      y_reg      <= result;
      zero_reg   <= ~|result;
      parity_reg <= ^result;
      acc_reg    <= result;
    end else if (ready_in) begin
      s2_valid   <= 1'b0;
    end
  end

  // Output drive
  always_comb begin
    valid_out  = s2_valid;
    y_out      = y_reg;
    zero_out   = zero_reg;
    parity_out = parity_reg;
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench for logic_unit_pipe at widths 8, 1 and 32.
// One instance per width shares the stimulus bus; sel picks the active one.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [2:0]  op_in = '0;
  logic        acc_in = 1'b0;
  logic        rdy_in = 1'b1;
  int          sel = 0;

  logic        r8, v8, z8, p8, r1, v1, z1, p1, r32, v32, z32, p32;
  logic [7:0]  y8;
  logic [0:0]  y1;
  logic [31:0] y32;

  logic        ready_o, valid_o, zero_o, parity_o;
  logic [31:0] y_o;

  always #5 clk = ~clk;

  logic_unit_pipe #(.DATA_WIDTH(8), .OPCODE_SIZE(3)) u8 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in && sel == 0), .ready_out(r8),
    .a_in(a_in[7:0]), .b_in(b_in[7:0]), .opcode_in(op_in), .acc_sel_in(acc_in),
    .valid_out(v8), .ready_in(sel == 0 ? rdy_in : 1'b1),
    .y_out(y8), .zero_out(z8), .parity_out(p8));

  logic_unit_pipe #(.DATA_WIDTH(1), .OPCODE_SIZE(3)) u1 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in && sel == 1), .ready_out(r1),
    .a_in(a_in[0:0]), .b_in(b_in[0:0]), .opcode_in(op_in), .acc_sel_in(acc_in),
    .valid_out(v1), .ready_in(sel == 1 ? rdy_in : 1'b1),
    .y_out(y1), .zero_out(z1), .parity_out(p1));

  logic_unit_pipe #(.DATA_WIDTH(32), .OPCODE_SIZE(3)) u32 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in && sel == 2), .ready_out(r32),
    .a_in(a_in), .b_in(b_in), .opcode_in(op_in), .acc_sel_in(acc_in),
    .valid_out(v32), .ready_in(sel == 2 ? rdy_in : 1'b1),
    .y_out(y32), .zero_out(z32), .parity_out(p32));

  // Route the selected instance to the common observation nets.
  always_comb begin
    case (sel)
      1:       begin ready_o = r1;  valid_o = v1;  y_o = {31'b0, y1}; zero_o = z1;  parity_o = p1;  end
      2:       begin ready_o = r32; valid_o = v32; y_o = y32;         zero_o = z32; parity_o = p32; end
      default: begin ready_o = r8;  valid_o = v8;  y_o = {24'b0, y8}; zero_o = z8;  parity_o = p8;  end
    endcase
  end

  typedef struct {
    logic [31:0] y;
    logic        z;
    logic        p;
    int          step;
    logic        lat;
  } item_t;

  item_t       q[$];
  logic [31:0] macc[3];
  int          vectors = 0;
  int          miss = 0;
  int          stepno = 0;
  logic        lat_chk = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_y;
  logic        prev_z, prev_p;

  function automatic int width_of(input int s);
    return (s == 1) ? 1 : (s == 2) ? 32 : 8;
  endfunction

  // Reference behaviour of one operation at width w.
  function automatic logic [31:0] lu(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] o, input int w);
    logic [31:0] r;
    logic [31:0] m;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case (o)
      3'd0:    r = a | b;
      3'd1:    r = a ^ b;
      3'd2:    r = a & b;
      3'd3:    r = ~a;
      3'd4:    r = ~(a | b);
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~(a & b);
      default: r = b;
    endcase
    return r & m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive after negedge, check outputs, push accepted beat after posedge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] o, input logic acc, input logic rdy,
                      input logic use_exp, input logic [31:0] exp_y, output logic taken);
    item_t it;
    logic [31:0] e;
    stepno++;
    valid_in = v; a_in = a; b_in = b; op_in = o; acc_in = acc; rdy_in = rdy;
    #1;
    if (prev_stall) begin
      check("stall_valid", {31'b0, valid_o}, 32'd1);
      check("stall_y", y_o, prev_y);
      check("stall_flags", {30'b0, zero_o, parity_o}, {30'b0, prev_z, prev_p});
    end
    if (q.size() == 2 && !rdy) check("ready_full", {31'b0, ready_o}, 32'd0);
    if (q.size() == 0) check("idle_hs", {30'b0, ready_o, valid_o}, 32'd2);
    taken = v && ready_o;
    if (valid_o && rdy) begin
      check("out_expected", {31'b0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        it = q.pop_front();
        check("y", y_o, it.y);
        check("zero", {31'b0, zero_o}, {31'b0, it.z});
        check("parity", {31'b0, parity_o}, {31'b0, it.p});
        if (it.lat) check("latency", stepno, it.step + 2);
      end
    end
    prev_stall = valid_o && !rdy;
    prev_y = y_o; prev_z = zero_o; prev_p = parity_o;
    @(posedge clk);
    if (taken) begin
      e = use_exp ? exp_y : lu(acc ? macc[sel] : a, b, o, width_of(sel));
      macc[sel] = e;
      it.y = e; it.z = (e == 32'd0); it.p = ^e; it.step = stepno; it.lat = lat_chk;
      q.push_back(it);
    end
    @(negedge clk);
  endtask

  // Offer a beat until accepted, ready_in high.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                      input logic acc, input logic use_exp, input logic [31:0] exp_y);
    logic t;
    t = 1'b0;
    for (int n = 0; n < 10 && !t; n++) step(1'b1, a, b, o, acc, 1'b1, use_exp, exp_y, t);
    check("send_accept", {31'b0, t}, 32'd1);
  endtask

  task automatic drain();
    logic t;
    for (int n = 0; n < 30 && (q.size() != 0 || valid_o); n++)
      step(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, 1'b0, '0, t);
    check("drain_empty", q.size(), 32'd0);
  endtask

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < 3; i++) macc[i] = '0;
    prev_stall = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic t;
    logic [7:0]  sweep_y[8];
    logic        hv;
    logic [31:0] ha, hb;
    logic [2:0]  ho;
    logic        hacc;
    int          k;

    sweep_y = '{8'hDB, 8'h99, 8'h42, 8'h3C, 8'h24, 8'h66, 8'hBD, 8'h5A};
    clear_model();

    // Reset state, every width
    @(negedge clk); @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check("rst_ready", {31'b0, ready_o}, 32'd1);
      check("rst_valid", {31'b0, valid_o}, 32'd0);
      check("rst_y", y_o, 32'd0);
      check("rst_flags", {30'b0, zero_o, parity_o}, 32'd2);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Accumulate chain straight out of reset
    send(32'h00, 32'h0F, 3'd0, 1'b1, 1'b1, 32'h0F);
    send(32'h00, 32'hFF, 3'd1, 1'b1, 1'b1, 32'hF0);
    drain();

    // Opcode sweep back-to-back, latency checked
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) send(32'hC3, 32'h5A, 3'(i), 1'b0, 1'b1, {24'b0, sweep_y[i]});
    drain();
    lat_chk = 1'b0;

    // Flag corner cases
    send(32'hFF, 32'hFF, 3'd1, 1'b0, 1'b1, 32'h00);
    send(32'h00, 32'h01, 3'd7, 1'b0, 1'b1, 32'h01);
    drain();

    // Backpressure: 4 beats, ready_in low for cycles 3..7
    k = 0;
    for (int c = 0; c < 20; c++) begin
      step(k < 4, 32'h21 + 32'(k) * 32'h11, 32'h96 - 32'(k) * 32'h0D, 3'(k + 1), 1'b0,
           !(c >= 3 && c < 8), 1'b0, '0, t);
      if (t) k++;
    end
    check("bp_all_sent", k, 32'd4);
    drain();

    // Reset with both stages full
    for (int n = 0; n < 6 && q.size() < 2; n++)
      step(1'b1, 32'hA5, 32'h3C, 3'd2, 1'b0, 1'b0, 1'b0, '0, t);
    check("fill_both", q.size(), 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, valid_o}, 32'd0);
    check("midrst_y", y_o, 32'd0);
    check("midrst_ready", {31'b0, ready_o}, 32'd1);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    send(32'hFF, 32'h00, 3'd0, 1'b1, 1'b1, 32'h00);
    drain();

    // Random streams on every width with random backpressure
    for (int s = 0; s < 3; s++) begin
      sel = s;
      hv = 1'b0; ha = '0; hb = '0; ho = '0; hacc = 1'b0;
      for (int n = 0; n < 300; n++) begin
        if (!hv) begin
          hv   = ($urandom_range(3) != 0);
          ha   = $urandom; hb = $urandom;
          ho   = 3'($urandom_range(7));
          hacc = ($urandom_range(1) == 1);
        end
        step(hv, ha, hb, ho, hacc, $urandom_range(2) != 0, 1'b0, '0, t);
        if (t || !hv) hv = 1'b0;
      end
      valid_in = 1'b0;
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
